// File: rtl/camera_controller_pkg.sv
// Shared defaults and types for the camera pose controller.
package camera_controller_pkg;

  localparam int COORD_WIDTH_DEF = 16;
  localparam int MOVE_SHIFT_DEF  = 4;
  localparam int TURN_STEP_DEF   = 'h0200;
  localparam int VERT_STEP_DEF   = 'h0040;
  localparam int PITCH_LIMIT_DEF = 'h3000;
  localparam int TIMEOUT_DEF     = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    START  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  typedef struct packed {
    logic fwd;
    logic back;
    logic left;
    logic right;
    logic up;
    logic down;
    logic rise;
    logic fall;
  } btn_t;

endpackage

// File: rtl/camera_sat_add.sv
// One-bit-wider add/subtract whose result is clamped to [lo, hi].
module camera_sat_add #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  input  logic signed [WIDTH-1:0] lo,
  input  logic signed [WIDTH-1:0] hi,
  output logic signed [WIDTH-1:0] sum
);

  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic signed [WIDTH:0] lo_ext;
  logic signed [WIDTH:0] hi_ext;
  logic signed [WIDTH:0] wide;

  always_comb begin
    a_ext  = a;
    b_ext  = b;
    lo_ext = lo;
    hi_ext = hi;
    wide   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    if (wide > hi_ext) begin
      sum = hi;
    end else if (wide < lo_ext) begin
      sum = lo;
    end else begin
      sum = wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/camera_controller.sv
// Camera pose controller: per-frame button integration and view-matrix handshake.
// Optional CAMERA_OVERRUN_CNT_EN adds overrun_count for frame ticks dropped while busy.
//
// state  | meaning
// IDLE   | waiting for frame_tick; buttons and forward_vec latched on accept
// UPDATE | pose registers take their new values at the end of this cycle
// START  | calc_start high for this one cycle
// WAIT   | waiting for calc_done, bounded by a TIMEOUT down-counter
module camera_controller
  import camera_controller_pkg::*;
#(
  parameter int                            COORD_WIDTH = COORD_WIDTH_DEF,
  parameter int                            MOVE_SHIFT  = MOVE_SHIFT_DEF,
  parameter logic signed [COORD_WIDTH-1:0] TURN_STEP   = COORD_WIDTH'(TURN_STEP_DEF),
  parameter logic signed [COORD_WIDTH-1:0] VERT_STEP   = COORD_WIDTH'(VERT_STEP_DEF),
  parameter logic signed [COORD_WIDTH-1:0] PITCH_LIMIT = COORD_WIDTH'(PITCH_LIMIT_DEF),
  parameter int                            TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                frame_tick,
  input  logic                                btn_fwd,
  input  logic                                btn_back,
  input  logic                                btn_left,
  input  logic                                btn_right,
  input  logic                                btn_up,
  input  logic                                btn_down,
  input  logic                                btn_rise,
  input  logic                                btn_fall,
  input  logic signed [2:0][COORD_WIDTH-1:0]  forward_vec,
  input  logic                                calc_done,
  output logic signed [COORD_WIDTH-1:0]       x_out,
  output logic signed [COORD_WIDTH-1:0]       y_out,
  output logic signed [COORD_WIDTH-1:0]       z_out,
  output logic signed [COORD_WIDTH-1:0]       rot_angle,
  output logic signed [COORD_WIDTH-1:0]       side_angle,
  output logic                                calc_start,
  output logic                                busy,
  output logic                                pose_valid,
  output logic                                timeout_err
`ifdef CAMERA_OVERRUN_CNT_EN
  ,
  output logic [7:0]                          overrun_count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic signed [COORD_WIDTH-1:0] POS_MAX   = {1'b0, {(COORD_WIDTH-1){1'b1}}};
  localparam logic signed [COORD_WIDTH-1:0] POS_MIN   = {1'b1, {(COORD_WIDTH-1){1'b0}}};
  localparam logic signed [COORD_WIDTH-1:0] PITCH_MIN = -PITCH_LIMIT;
  localparam logic [CNT_W-1:0]              WAIT_LOAD = CNT_W'(TIMEOUT - 1);

  state_t                         state;
  btn_t                           btn_q;
  logic signed [COORD_WIDTH-1:0]  fx_q;
  logic signed [COORD_WIDTH-1:0]  fz_q;
  logic [CNT_W-1:0]               wait_cnt;

  logic signed [COORD_WIDTH-1:0]  step_x;
  logic signed [COORD_WIDTH-1:0]  step_z;
  logic signed [COORD_WIDTH-1:0]  move_x;
  logic signed [COORD_WIDTH-1:0]  move_z;
  logic signed [COORD_WIDTH-1:0]  vert_d;
  logic signed [COORD_WIDTH-1:0]  pitch_d;
  logic signed [COORD_WIDTH-1:0]  yaw_d;
  logic signed [COORD_WIDTH-1:0]  x_next;
  logic signed [COORD_WIDTH-1:0]  y_next;
  logic signed [COORD_WIDTH-1:0]  z_next;
  logic signed [COORD_WIDTH-1:0]  rot_next;
  logic signed [COORD_WIDTH-1:0]  side_next;

  // The y component of the heading is not used for ground-plane motion.
  logic unused_fy;
  assign unused_fy = ^forward_vec[1];

  // Opposing buttons cancel: the delta is zeroed and the sub flag then has no effect.
  assign step_x    = fx_q >>> MOVE_SHIFT;
  assign step_z    = fz_q >>> MOVE_SHIFT;
  assign move_x    = (btn_q.fwd ^ btn_q.back) ? step_x : '0;
  assign move_z    = (btn_q.fwd ^ btn_q.back) ? step_z : '0;
  assign vert_d    = (btn_q.rise ^ btn_q.fall) ? VERT_STEP : '0;
  assign pitch_d   = (btn_q.up ^ btn_q.down) ? TURN_STEP : '0;
  assign yaw_d     = (btn_q.left ^ btn_q.right) ? (btn_q.right ? TURN_STEP : -TURN_STEP) : '0;
  assign side_next = side_angle + yaw_d;

  camera_sat_add #(.WIDTH(COORD_WIDTH)) u_sat_x (
    .a(x_out), .b(move_x), .sub(btn_q.back), .lo(POS_MIN), .hi(POS_MAX), .sum(x_next)
  );
  camera_sat_add #(.WIDTH(COORD_WIDTH)) u_sat_y (
    .a(y_out), .b(vert_d), .sub(btn_q.fall), .lo(POS_MIN), .hi(POS_MAX), .sum(y_next)
  );
  camera_sat_add #(.WIDTH(COORD_WIDTH)) u_sat_z (
    .a(z_out), .b(move_z), .sub(btn_q.back), .lo(POS_MIN), .hi(POS_MAX), .sum(z_next)
  );
  camera_sat_add #(.WIDTH(COORD_WIDTH)) u_sat_pitch (
    .a(rot_angle), .b(pitch_d), .sub(btn_q.down), .lo(PITCH_MIN), .hi(PITCH_LIMIT), .sum(rot_next)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      btn_q       <= '0;
      fx_q        <= '0;
      fz_q        <= '0;
      wait_cnt    <= '0;
      x_out       <= '0;
      y_out       <= '0;
      z_out       <= '0;
      rot_angle   <= '0;
      side_angle  <= '0;
      calc_start  <= 1'b0;
      busy        <= 1'b0;
      pose_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      calc_start  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            btn_q <= '{fwd: btn_fwd, back: btn_back, left: btn_left, right: btn_right,
                       up: btn_up, down: btn_down, rise: btn_rise, fall: btn_fall};
            fx_q  <= forward_vec[0];
            fz_q  <= forward_vec[2];
            state <= UPDATE;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          x_out      <= x_next;
          y_out      <= y_next;
          z_out      <= z_next;
          rot_angle  <= rot_next;
          side_angle <= side_next;
          calc_start <= 1'b1;
          state      <= START;
        end
        START: begin
          wait_cnt <= WAIT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          // A completion in the final counted cycle still wins over the timeout.
          if (calc_done) begin
            pose_valid <= 1'b1;
            wait_cnt   <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
          end else if (wait_cnt == '0) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAMERA_OVERRUN_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overrun_count <= '0;
    end else if (frame_tick && (state != IDLE) && (overrun_count != 8'hFF)) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/camera_controller.md
CAMERA_CONTROLLER -- requirements
Module: camera_controller

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 16: width of all coordinates, angles and vector components.
REQ-002 SHALL have parameter MOVE_SHIFT, default 4: arithmetic right shift applied to forward_vec components per move step.
REQ-003 SHALL have parameter TURN_STEP, default 16'h0200: angle increment per frame per turn button.
REQ-004 SHALL have parameter VERT_STEP, default 16'h0040: y increment per frame per rise/fall button.
REQ-005 SHALL have parameter PITCH_LIMIT, default 16'h3000: rot_angle magnitude clamp (positive, signed).
REQ-006 SHALL have parameter TIMEOUT, default 1024: max WAIT cycles for calc_done.
REQ-007 clk_in  input  1  single system clock, all logic on rising edge.
REQ-008 rst_in  input  1  synchronous, active-high reset.
REQ-009 frame_tick  input  1  one-cycle pulse requesting one pose update.
REQ-010 btn_fwd, btn_back, btn_left, btn_right, btn_up, btn_down, btn_rise, btn_fall  input  1 each  level-sensitive movement controls.
REQ-011 forward_vec  input  [2:0][COORD_WIDTH-1:0] signed  heading vector from view matrix calculator; [0]=x, [2]=z.
REQ-012 calc_done  input  1  completion pulse from view matrix calculator.
REQ-013 x_out, y_out, z_out  output  COORD_WIDTH signed  camera position.
REQ-014 rot_angle, side_angle  output  COORD_WIDTH signed  pitch and yaw.
REQ-015 calc_start  output  1  one-cycle start pulse to view matrix calculator.
REQ-016 busy  output  1  high whenever state != IDLE.
REQ-017 pose_valid  output  1  high once the first calculation completes; cleared only by reset.
REQ-018 timeout_err  output  1  one-cycle pulse when WAIT exceeds TIMEOUT.

Function
REQ-019 SHALL implement FSM IDLE -> UPDATE -> START -> WAIT -> IDLE.
REQ-020 IDLE: on frame_tick, latch all buttons and forward_vec, go UPDATE; frame_tick in any other state SHALL be ignored.
REQ-021 UPDATE (one cycle): yaw side_angle += TURN_STEP (btn_right) / -= TURN_STEP (btn_left), wrap modulo 2^COORD_WIDTH; both pressed -> unchanged.
REQ-022 UPDATE: pitch rot_angle += TURN_STEP (btn_up) / -= (btn_down), result clamped to [-PITCH_LIMIT, +PITCH_LIMIT]; both pressed -> unchanged.
REQ-023 UPDATE: btn_fwd -> x += forward_vec[0]>>>MOVE_SHIFT, z += forward_vec[2]>>>MOVE_SHIFT; btn_back subtracts same; both -> no motion.
REQ-024 UPDATE: btn_rise -> y += VERT_STEP, btn_fall -> y -= VERT_STEP; both -> unchanged.
REQ-025 Position sums SHALL use COORD_WIDTH+1 bits and saturate to signed COORD_WIDTH range; no wrap.
REQ-026 New pose registers SHALL update at end of UPDATE and hold stable through START and WAIT.
REQ-027 START: calc_start=1 for exactly one cycle (cycle N+2 for frame_tick at cycle N), go WAIT.
REQ-028 WAIT: calc_done -> set pose_valid, go IDLE; counter reaching TIMEOUT -> pulse timeout_err, go IDLE, pose retained.
REQ-029 calc_done seen outside WAIT SHALL be ignored.
REQ-030 Earliest next accepted frame_tick SHALL be the cycle after return to IDLE.

Reset
REQ-031 rst_in SHALL force state IDLE, all position/angle outputs 0, calc_start, busy, pose_valid, timeout_err 0, wait counter 0.
REQ-032 rst_in mid-operation (any state) SHALL abort immediately; no calc_start issued afterwards until a new frame_tick.

Configuration
REQ-033 Macro CAMERA_OVERRUN_CNT_EN defined: add output overrun_count [7:0], increments (saturating at 255) on each frame_tick ignored while busy, reset 0.
REQ-034 Macro undefined: port and counter absent; dropped ticks silently ignored.

Structure
REQ-035 Shared package SHALL hold COORD_WIDTH default, state enum type, and angle/step default constants.
REQ-036 One sub-module natural: camera_sat_add (width+1 add with signed saturation/clamp), instantiated for x, y, z, pitch.

Verification
REQ-037 forward_vec=(16'h0100,0,16'h7F00), btn_fwd, tick -> x_out=16'h0010, z_out=16'h07F0, calc_start at tick+2.
REQ-038 side_angle=16'hFF00, btn_right, tick -> side_angle=16'h0100 (wrap).
REQ-039 rot_angle=16'h2F00, btn_up, tick -> rot_angle=16'h3000 (clamp); repeat -> stays 16'h3000.
REQ-040 x_out=16'h7FF8, forward_vec[0]=16'h0200, btn_fwd -> x_out=16'h7FFF (saturate).
REQ-041 No calc_done for 1024 WAIT cycles -> timeout_err pulse, busy=0, pose unchanged; extra ticks in WAIT -> no second calc_start (overrun_count increments if enabled).
REQ-042 rst_in asserted during WAIT -> next cycle all outputs 0, busy=0, later calc_done ignored.
